// File: rtl/prog_clock_divider.sv
// Runtime-programmable integer clock divider with a one-cycle enable pulse,
// a divided clock that is high for ceil(D/2) cycles, and fixed power-of-two taps.
module prog_clock_divider #(
  parameter int DIV_W     = 8,
  parameter int NUM_TAPS  = 3,
  parameter int RESET_DIV = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    div_val,
  input  logic                div_load,
  output logic                div_pending,
  output logic                clk_div,
  output logic                clk_en,
  output logic [NUM_TAPS-1:0] clk_pow2
);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    cnt_reg, cnt_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic [DIV_W-1:0]    pend_val_reg, pend_val_next;
  logic                pend_reg, pend_next;
  logic                clk_div_reg, clk_div_next;
  logic                clk_en_reg, clk_en_next;
  logic [NUM_TAPS-1:0] taps_reg;

  logic                boundary;
  logic [DIV_W-1:0]    div_new;
  logic [DIV_W-1:0]    div_sel;
  logic [DIV_W:0]      half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_STOP;
      cnt_reg      <= '0;
      div_reg      <= DIV_W'(RESET_DIV);
      pend_val_reg <= '0;
      pend_reg     <= 1'b0;
      clk_div_reg  <= 1'b0;
      clk_en_reg   <= 1'b0;
      taps_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      div_reg      <= div_next;
      pend_val_reg <= pend_val_next;
      pend_reg     <= pend_next;
      clk_div_reg  <= clk_div_next;
      clk_en_reg   <= clk_en_next;
      taps_reg     <= taps_reg + NUM_TAPS'(1);
    end
  end

  // A stopped divider treats every edge as a period boundary, so a pending
  // divisor (or the reset divisor right after reset) starts its period at once.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    div_next      = div_reg;
    pend_val_next = pend_val_reg;
    pend_next     = pend_reg;
    clk_div_next  = 1'b0;
    clk_en_next   = 1'b0;

    boundary = (state_reg == ST_STOP) || (cnt_reg == div_reg - DIV_W'(1));
    div_new  = pend_reg ? pend_val_reg : div_reg;
    div_sel  = boundary ? div_new : div_reg;
    half     = ({1'b0, div_sel} + (DIV_W+1)'(1)) >> 1;

    if (boundary) begin
      div_next  = div_new;
      pend_next = 1'b0;
      cnt_next  = '0;
      if (div_new == '0) begin
        state_next = ST_STOP;
      end else begin
        state_next   = ST_RUN;
        clk_en_next  = 1'b1;
        clk_div_next = 1'b1;
      end
    end else begin
      cnt_next     = cnt_reg + DIV_W'(1);
      clk_div_next = ({1'b0, cnt_next} < half);
    end

    // A load on a boundary edge queues behind the value applied on that edge.
    if (div_load) begin
      pend_val_next = div_val;
      pend_next     = 1'b1;
    end
  end

  assign div_pending = pend_reg;
  assign clk_div     = clk_div_reg;
  assign clk_en      = clk_en_reg;
  assign clk_pow2    = taps_reg;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: reset, D=2/5/3/0/4/1/255 periods,
// pending-divisor handling and mid-period reset.
module tb_prog_clock_divider;

  logic       clk;
  logic       rst;
  logic [7:0] div_val;
  logic       div_load;
  logic       div_pending;
  logic       clk_div;
  logic       clk_en;
  logic [2:0] clk_pow2;

  int errors = 0;
  int checks = 0;
  int tcount = 0;

  prog_clock_divider #(.DIV_W(8), .NUM_TAPS(3), .RESET_DIV(2)) dut (
    .clk(clk),
    .rst(rst),
    .div_val(div_val),
    .div_load(div_load),
    .div_pending(div_pending),
    .clk_div(clk_div),
    .clk_en(clk_en),
    .clk_pow2(clk_pow2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge (reset released) and check the free-running taps.
  task automatic step();
    @(posedge clk);
    #1;
    tcount++;
    chk("clk_pow2", {29'd0, clk_pow2}, tcount % 8);
  endtask

  // Walk cycles c0..c1 of a period of length d, checking the expected waveform.
  task automatic chk_cycles(input int d, input int c0, input int c1, input logic pend);
    for (int c = c0; c <= c1; c++) begin
      step();
      chk("clk_div", {31'd0, clk_div}, (c < (d + 1) / 2) ? 1 : 0);
      chk("clk_en", {31'd0, clk_en}, (c == 0) ? 1 : 0);
      chk("div_pending", {31'd0, div_pending}, {31'd0, pend});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clk_div"}, {31'd0, clk_div}, 0);
    chk({tag, "_clk_en"}, {31'd0, clk_en}, 0);
    chk({tag, "_pending"}, {31'd0, div_pending}, 0);
    chk({tag, "_pow2"}, {29'd0, clk_pow2}, 0);
  endtask

  initial begin
    rst      = 1'b1;
    div_val  = 8'd0;
    div_load = 1'b0;

    // Reset held across the edge at 10 ns; released at 25 ns.
    #11;
    chk_zero("reset");
    #14;
    rst = 1'b0;
    #1;
    chk_zero("release");

    // D=2 after reset: two full periods
    chk_cycles(2, 0, 1, 1'b0);
    chk_cycles(2, 0, 1, 1'b0);

    // Load D=5 mid-period
    chk_cycles(2, 0, 0, 1'b0);
    div_val = 8'd5; div_load = 1'b1;
    chk_cycles(2, 1, 1, 1'b1);
    div_load = 1'b0;
    chk_cycles(5, 0, 4, 1'b0);
    chk_cycles(5, 0, 0, 1'b0);

    // D=7 then D=3 on consecutive edges: last one wins
    div_val = 8'd7; div_load = 1'b1;
    chk_cycles(5, 1, 1, 1'b1);
    div_val = 8'd3;
    chk_cycles(5, 2, 2, 1'b1);
    div_load = 1'b0;
    chk_cycles(5, 3, 4, 1'b1);
    chk_cycles(3, 0, 2, 1'b0);
    chk_cycles(3, 0, 2, 1'b0);

    // D=0 stops the divider
    chk_cycles(3, 0, 0, 1'b0);
    div_val = 8'd0; div_load = 1'b1;
    chk_cycles(3, 1, 1, 1'b1);
    div_load = 1'b0;
    chk_cycles(3, 2, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stop_clk_div", {31'd0, clk_div}, 0);
      chk("stop_clk_en", {31'd0, clk_en}, 0);
      chk("stop_pending", {31'd0, div_pending}, 0);
    end

    // D=4 while stopped: captured, then its period starts on the next edge
    div_val = 8'd4; div_load = 1'b1;
    step();
    chk("stop_load_clk_div", {31'd0, clk_div}, 0);
    chk("stop_load_clk_en", {31'd0, clk_en}, 0);
    chk("stop_load_pending", {31'd0, div_pending}, 1);
    div_load = 1'b0;
    chk_cycles(4, 0, 3, 1'b0);
    chk_cycles(4, 0, 3, 1'b0);

    // D=1: enable every cycle, clk_div held high
    chk_cycles(4, 0, 0, 1'b0);
    div_val = 8'd1; div_load = 1'b1;
    chk_cycles(4, 1, 1, 1'b1);
    div_load = 1'b0;
    chk_cycles(4, 2, 3, 1'b1);
    for (int i = 0; i < 4; i++) chk_cycles(1, 0, 0, 1'b0);

    // D=255: high 128 / low 127, then a clean wrap
    div_val = 8'd255; div_load = 1'b1;
    chk_cycles(1, 0, 0, 1'b1);
    div_load = 1'b0;
    chk_cycles(255, 0, 254, 1'b0);
    chk_cycles(255, 0, 0, 1'b0);

    // Reset mid-period with D=9 pending
    div_val = 8'd9; div_load = 1'b1;
    chk_cycles(255, 1, 1, 1'b1);
    div_load = 1'b0;
    chk_cycles(255, 2, 5, 1'b1);
    rst = 1'b1;
    #2;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    chk_zero("midrst_edge");
    #4;
    rst = 1'b0;
    tcount = 0;
    chk_cycles(2, 0, 1, 1'b0);
    chk_cycles(2, 0, 1, 1'b0);
    chk_cycles(2, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
